// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the I/D single-port memory arbiter
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

   function automatic logic word_aligned(input logic [1:0] lsbs);
      return (lsbs & WORD_ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of one word memory between fetch (I) and load/store (D)
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int AW      = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ireq,
   input  logic [AW-1:0] iaddr,
   output logic          idone,
   output logic [31:0]   irdata,
   output logic          ierr,
   input  logic          dreq,
   input  logic          dwrite,
   input  logic [AW-1:0] daddr,
   input  logic [31:0]   dwdata,
   output logic          ddone,
   output logic [31:0]   drdata,
   output logic          derr,
   output logic [AW-1:0] address,
   output logic [31:0]   memIn,
   output logic          read,
   output logic          write,
   input  logic [31:0]   memOut
);

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   state_e          state_q, state_d;
   logic            gnt_q, gnt_d;
   logic            last_grant_q, last_grant_d;
   logic            we_q, we_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   address_q, address_d;
   logic [31:0]     mem_in_q, mem_in_d;
   logic            read_q, read_d;
   logic            write_q, write_d;
   logic            idone_q, idone_d;
   logic            ddone_q, ddone_d;
   logic [31:0]     irdata_q, irdata_d;
   logic [31:0]     drdata_q, drdata_d;
   logic            ierr_q, ierr_d;
   logic            derr_q, derr_d;

   logic            sel;
   logic [AW-1:0]   sel_addr;
   logic            sel_we;

   // Conflicts go to the port that did not win last time.
   always_comb begin
      if (ireq && dreq) begin
         sel = ~last_grant_q;
      end else if (dreq) begin
         sel = PORT_D;
      end else begin
         sel = PORT_I;
      end
      sel_addr = (sel == PORT_D) ? daddr : iaddr;
      sel_we   = (sel == PORT_D) && dwrite;
   end

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      cnt_d        = cnt_q;
      address_d    = address_q;
      mem_in_d     = mem_in_q;
      read_d       = read_q;
      write_d      = write_q;
      idone_d      = 1'b0;
      ddone_d      = 1'b0;
      irdata_d     = irdata_q;
      drdata_d     = drdata_q;
      ierr_d       = ierr_q;
      derr_d       = derr_q;

      case (state_q)
         ST_IDLE: begin
            if (ireq || dreq) begin
               gnt_d        = sel;
               last_grant_d = sel;
               we_d         = sel_we;
               address_d    = sel_addr;
               if (!word_aligned(sel_addr[1:0])) begin
                  // Misaligned: answer straight away, memory is never touched.
                  state_d = ST_RESP;
                  if (sel == PORT_I) begin
                     idone_d = 1'b1;
                     ierr_d  = 1'b1;
                  end else begin
                     ddone_d = 1'b1;
                     derr_d  = 1'b1;
                  end
               end else begin
                  state_d  = ST_ACCESS;
                  read_d   = ~sel_we;
                  write_d  = sel_we;
                  mem_in_d = sel_we ? dwdata : 32'd0;
                  cnt_d    = CW'(MEM_LAT - 1);
               end
            end
         end

         ST_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
               read_d  = 1'b0;
               write_d = 1'b0;
               if (gnt_q == PORT_I) begin
                  idone_d  = 1'b1;
                  ierr_d   = 1'b0;
                  irdata_d = memOut;
               end else begin
                  ddone_d = 1'b1;
                  derr_d  = 1'b0;
                  if (!we_q) begin
                     drdata_d = memOut;
                  end
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            read_d  = 1'b0;
            write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         gnt_q        <= PORT_I;
         last_grant_q <= PORT_I;
         we_q         <= 1'b0;
         cnt_q        <= '0;
         address_q    <= '0;
         mem_in_q     <= 32'd0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         idone_q      <= 1'b0;
         ddone_q      <= 1'b0;
         irdata_q     <= 32'd0;
         drdata_q     <= 32'd0;
         ierr_q       <= 1'b0;
         derr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         cnt_q        <= cnt_d;
         address_q    <= address_d;
         mem_in_q     <= mem_in_d;
         read_q       <= read_d;
         write_q      <= write_d;
         idone_q      <= idone_d;
         ddone_q      <= ddone_d;
         irdata_q     <= irdata_d;
         drdata_q     <= drdata_d;
         ierr_q       <= ierr_d;
         derr_q       <= derr_d;
      end
   end

   assign idone   = idone_q;
   assign irdata  = irdata_q;
   assign ierr    = ierr_q;
   assign ddone   = ddone_q;
   assign drdata  = drdata_q;
   assign derr    = derr_q;
   assign address = address_q;
   assign memIn   = mem_in_q;
   assign read    = read_q;
   assign write   = write_q;

endmodule
